mac_acc_block: RTL and testbench
================================

MAC_ACC_BLOCK -- requirements
Module: mac_acc_block

Interface
REQ-001 SHALL have parameter MAC_CONF_WIDTH, default 2, config select width.
REQ-002 SHALL have parameter MAC_MIN_WIDTH, default 8, minimum lane operand width.
REQ-003 SHALL have parameter MAC_PROD_WIDTH, default 8*MAC_MIN_WIDTH (64), packed product width.
REQ-004 SHALL have parameter MAC_ACC_WIDTH, default 10*MAC_MIN_WIDTH (80), packed accumulator width.
REQ-005 SHALL have parameter MAC_LEN_WIDTH, default 8, accumulation length width.
REQ-006 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg  in  MAC_CONF_WIDTH  mode: 00 single, 01 dual, 10 quad; 11 behaves as single.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block accepts a beat.
- prod  in  MAC_PROD_WIDTH  packed unsigned products: single 4x16b, dual 2x32b, quad 1x64b, lane 0 in the LSBs.
- acc_len  in  MAC_LEN_WIDTH  beats per result; sampled on the first beat.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  MAC_ACC_WIDTH  packed sums: single 4x20b, dual 2x40b, quad 1x80b.
- ovf  out  MAC_ACC_WIDTH/20  per-20b-slice sticky overflow flag, valid with out_data.

Function
REQ-007 SHALL accept a beat only when in_valid && in_ready are both high on a rising edge.
REQ-008 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-009 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-010 SHALL, on a beat accepted in IDLE:
- latch cfg and acc_len (acc_len 0 treated as 1);
- zero-extend each product lane into its accumulator lane and load it;
- set the beat count to 1;
- go to HOLD if the length is 1, else to ACCUM.
REQ-011 SHALL, on a beat accepted in ACCUM:
- add each zero-extended lane to its accumulator lane;
- increment the count;
- go to HOLD when the count reaches the latched length.
REQ-012 SHALL block carries at lane boundaries per the latched cfg: 20b lanes in single, 40b in dual, none in quad.
REQ-013 SHALL interpret prod per the latched cfg for every beat; cfg changes after the first beat are ignored until IDLE.
REQ-014 SHALL assert out_valid only in HOLD, with out_data equal to the accumulator register, so the result appears the cycle after the last beat.
REQ-015 SHALL hold out_data and ovf stable while out_valid && !out_ready.
REQ-016 SHALL, on out_valid && out_ready, clear the accumulator and ovf and return to IDLE; the next beat is accepted no earlier than the following cycle.
REQ-017 SHALL set an ovf bit when the carry out of that lane's MSB occurs; in dual and quad every ovf bit of the affected lane is set.
REQ-018 SHALL treat in_valid while in HOLD as a stall; no beat is consumed.

Reset
REQ-019 SHALL, while rst is low, force state IDLE, accumulator 0, count 0, ovf 0, out_valid 0 and in_ready 0.
REQ-020 SHALL drive in_ready 1 from the first clock edge after rst deasserts.
REQ-021 SHALL discard any partial accumulation when reset is asserted mid-operation, with no result emitted.

Configuration
REQ-022 SHALL, when macro MAC_ACC_SATURATE_EN is defined, clamp an overflowing lane to all-ones and hold it there for the remainder of the accumulation.
REQ-023 SHALL, when MAC_ACC_SATURATE_EN is undefined, wrap an overflowing lane modulo 2^lane-width; ovf behaviour is identical in both builds.

Structure
REQ-024 SHALL take the cfg encodings (single/dual/quad), the FSM state encodings and the lane widths from shared header mac_const.vh.
REQ-025 SHALL place the lane-segmented add (carry-kill and saturate) in one sub-module, mac_lane_adder; the FSM, counter and handshake stay in mac_acc_block.

Verification
REQ-026 SHALL cover these directed scenarios:
- Single, acc_len=3, lane products 16'h0001/0002/0003/FFFF x3 beats -> out_data lanes 20'h3, 20'h6, 20'h9, 20'h2FFFD; ovf=0.
- Quad, acc_len=2, prod=64'hFFFF_FFFF_FFFF_FFFF twice -> out_data=80'h1_FFFF_FFFF_FFFF_FFFE; no carry kill.
- Dual, acc_len=1, prod={32'h8000_0000,32'h1} -> lanes 40'h80000000, 40'h1; out_valid the cycle after acceptance.
- Back-pressure: out_ready=0 for 5 cycles -> out_data stable, in_ready=0, in_valid beats not consumed; then release -> IDLE.
- Overflow, single acc_len=255, lane0=16'hFFFF each beat -> ovf[0]=1; with MAC_ACC_SATURATE_EN lane0=20'hFFFFF, without it lane0 is the wrapped value; other lanes unaffected.
- rst low after 2 of 4 beats -> out_valid never asserts; the next 1-beat run returns that beat alone.

Source files
------------

// File: rtl/mac_acc_block_pkg.sv
// Shared constants for the MAC accumulator: cfg encodings, FSM states, lane geometry.
package mac_acc_block_pkg;

  // ovf and carry-kill granularity: one flag per 20-bit accumulator slice
  localparam int unsigned SEG_ACC_W = 20;

  typedef enum logic [1:0] {
    CFG_SINGLE = 2'b00,
    CFG_DUAL   = 2'b01,
    CFG_QUAD   = 2'b10
  } mac_cfg_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } mac_state_e;

  // 2'b11 is reserved and behaves as single
  function automatic mac_cfg_e cfg_decode(input logic [1:0] c);
    case (c)
      2'b01:   return CFG_DUAL;
      2'b10:   return CFG_QUAD;
      default: return CFG_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/mac_lane_adder.sv
// Lane-segmented accumulate add with per-mode carry kill; wraps by default,
// clamps overflowing lanes to all-ones when MAC_ACC_SATURATE_EN is defined.
module mac_lane_adder
  import mac_acc_block_pkg::*;
#(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned ACC_W  = 80
) (
  input  mac_cfg_e                      mode,
  input  logic [ACC_W-1:0]              acc_in,
  input  logic [PROD_W-1:0]             prod,
  output logic [ACC_W-1:0]              sum,
  output logic [ACC_W/SEG_ACC_W-1:0]    lane_ovf
);

  localparam int unsigned NSEG = ACC_W / SEG_ACC_W;
  localparam int unsigned PS   = PROD_W / NSEG;
  localparam int unsigned AS   = SEG_ACC_W;

  logic [ACC_W-1:0] add_single;
  logic [ACC_W-1:0] add_dual;
  logic [ACC_W-1:0] add_quad;
  logic [ACC_W-1:0] addend;
  logic [NSEG-1:0]  cout;

  for (genvar k = 0; k < NSEG; k++) begin : g_single
    assign add_single[k*AS +: AS] = AS'(prod[k*PS +: PS]);
  end

  for (genvar j = 0; j < NSEG/2; j++) begin : g_dual
    assign add_dual[j*2*AS +: 2*AS] = (2*AS)'(prod[j*2*PS +: 2*PS]);
  end

  assign add_quad = ACC_W'(prod);

  always_comb begin
    logic       carry;
    logic       cin;
    logic [AS:0] seg;
    sum      = '0;
    lane_ovf = '0;
    cout     = '0;
    carry    = 1'b0;
    case (mode)
      CFG_DUAL: addend = add_dual;
      CFG_QUAD: addend = add_quad;
      default:  addend = add_single;
    endcase

    for (int unsigned k = 0; k < NSEG; k++) begin
      case (mode)
        CFG_DUAL: cin = (k % 2 == 0) ? 1'b0 : carry;
        CFG_QUAD: cin = (k == 0) ? 1'b0 : carry;
        default:  cin = 1'b0;
      endcase
      seg = {1'b0, acc_in[k*AS +: AS]} + {1'b0, addend[k*AS +: AS]} + {{AS{1'b0}}, cin};
      sum[k*AS +: AS] = seg[AS-1:0];
      cout[k] = seg[AS];
      carry   = seg[AS];
    end

    // a lane overflows on the carry out of its top slice; flag every slice it spans
    for (int unsigned k = 0; k < NSEG; k++) begin
      case (mode)
        CFG_DUAL: lane_ovf[k] = cout[k | 1];
        CFG_QUAD: lane_ovf[k] = cout[NSEG-1];
        default:  lane_ovf[k] = cout[k];
      endcase
    end

`ifdef MAC_ACC_SATURATE_EN
    for (int unsigned k = 0; k < NSEG; k++) begin
      if (lane_ovf[k]) sum[k*AS +: AS] = '1;
    end
`endif
  end

endmodule

// File: rtl/mac_acc_block.sv
// Packed multi-lane MAC accumulator: FSM, beat counter and handshake.
// Optional build macro MAC_ACC_SATURATE_EN selects saturating lanes (default wraps).
module mac_acc_block
  import mac_acc_block_pkg::*;
#(
  parameter int unsigned MAC_CONF_WIDTH = 2,
  parameter int unsigned MAC_MIN_WIDTH  = 8,
  parameter int unsigned MAC_PROD_WIDTH = 8 * MAC_MIN_WIDTH,
  parameter int unsigned MAC_ACC_WIDTH  = 10 * MAC_MIN_WIDTH,
  parameter int unsigned MAC_LEN_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MAC_CONF_WIDTH-1:0]   cfg,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MAC_PROD_WIDTH-1:0]   prod,
  input  logic [MAC_LEN_WIDTH-1:0]    acc_len,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MAC_ACC_WIDTH-1:0]    out_data,
  output logic [MAC_ACC_WIDTH/20-1:0] ovf
);

  localparam int unsigned NSEG = MAC_ACC_WIDTH / SEG_ACC_W;

  mac_state_e               state;
  mac_cfg_e                 mode_q;
  mac_cfg_e                 mode_sel;
  logic [MAC_LEN_WIDTH-1:0] len_q;
  logic [MAC_LEN_WIDTH-1:0] len_eff;
  logic [MAC_LEN_WIDTH-1:0] cnt;
  logic [MAC_LEN_WIDTH-1:0] cnt_inc;
  logic [MAC_ACC_WIDTH-1:0] acc_q;
  logic [MAC_ACC_WIDTH-1:0] acc_base;
  logic [MAC_ACC_WIDTH-1:0] sum;
  logic [NSEG-1:0]          ovf_q;
  logic [NSEG-1:0]          lane_ovf;
  logic                     beat;

  assign beat    = in_valid && in_ready;
  assign len_eff = (acc_len == '0) ? MAC_LEN_WIDTH'(1) : acc_len;
  assign cnt_inc = cnt + MAC_LEN_WIDTH'(1);

  // the first beat uses live cfg and an empty accumulator; later beats use the latched mode
  assign mode_sel = (state == ST_IDLE) ? cfg_decode(cfg[1:0]) : mode_q;
  assign acc_base = (state == ST_IDLE) ? '0 : acc_q;

  mac_lane_adder #(
    .PROD_W (MAC_PROD_WIDTH),
    .ACC_W  (MAC_ACC_WIDTH)
  ) u_lane_adder (
    .mode     (mode_sel),
    .acc_in   (acc_base),
    .prod     (prod),
    .sum      (sum),
    .lane_ovf (lane_ovf)
  );

  assign out_data = acc_q;
  assign ovf      = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mode_q    <= CFG_SINGLE;
      len_q     <= '0;
      cnt       <= '0;
      acc_q     <= '0;
      ovf_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (beat) begin
            mode_q <= mode_sel;
            len_q  <= len_eff;
            acc_q  <= sum;
            ovf_q  <= lane_ovf;
            cnt    <= MAC_LEN_WIDTH'(1);
            if (len_eff == MAC_LEN_WIDTH'(1)) begin
              state     <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            acc_q <= sum;
            ovf_q <= ovf_q | lane_ovf;
            cnt   <= cnt_inc;
            if (cnt_inc == len_q) begin
              state     <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            acc_q     <= '0;
            ovf_q     <= '0;
            cnt       <= '0;
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_acc_block.sv
// Self-checking bench for mac_acc_block: directed scenarios plus randomized
// transactions checked against a lane-arithmetic reference model.
module tb_mac_acc_block;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  cfg = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] prod = '0;
  logic [7:0]  acc_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [79:0] out_data;
  logic [3:0]  ovf;

  int n_vec = 0;
  int n_err = 0;

  mac_acc_block #(
    .MAC_CONF_WIDTH (2),
    .MAC_MIN_WIDTH  (8),
    .MAC_PROD_WIDTH (64),
    .MAC_ACC_WIDTH  (80),
    .MAC_LEN_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .acc_len   (acc_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: each lane is an independent unsigned counter of width m_aw
  logic [127:0] m_lane [4];
  bit           m_ovf  [4];
  int           m_nl, m_pw, m_aw;

  task automatic m_start(input logic [1:0] c);
    case (c)
      2'b01:   begin m_nl = 2; m_pw = 32; m_aw = 40; end
      2'b10:   begin m_nl = 1; m_pw = 64; m_aw = 80; end
      default: begin m_nl = 4; m_pw = 16; m_aw = 20; end
    endcase
    for (int l = 0; l < 4; l++) begin
      m_lane[l] = '0;
      m_ovf[l]  = 1'b0;
    end
  endtask

  task automatic m_beat(input logic [63:0] p);
    logic [127:0] pm, am, v, s;
    pm = (128'd1 << m_pw) - 128'd1;
    am = (128'd1 << m_aw) - 128'd1;
    for (int l = 0; l < m_nl; l++) begin
      v = ({64'd0, p} >> (l * m_pw)) & pm;
      s = m_lane[l] + v;
      if (s > am) m_ovf[l] = 1'b1;
`ifdef MAC_ACC_SATURATE_EN
      if (m_ovf[l]) s = am;
`else
      s = s & am;
`endif
      m_lane[l] = s;
    end
  endtask

  function automatic logic [79:0] m_data();
    logic [127:0] d;
    d = '0;
    for (int l = 0; l < m_nl; l++) d = d | (m_lane[l] << (l * m_aw));
    return d[79:0];
  endfunction

  function automatic logic [3:0] m_ovfv();
    logic [3:0] o;
    for (int k = 0; k < 4; k++) o[k] = m_ovf[k / (4 / m_nl)];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [1:0] c, input logic [7:0] len, input logic [63:0] p);
    int n;
    in_valid = 1'b1;
    cfg      = c;
    acc_len  = len;
    prod     = p;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("beat_timeout", 128'd0, 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [79:0] exp_d,
                               input logic [3:0] exp_o, input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_ovf"}, ovf, exp_o);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold"}, {out_valid, in_ready, ovf, out_data}, {1'b1, 1'b0, exp_o, exp_d});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic rnd_txn();
    logic [1:0]  c;
    logic [7:0]  len;
    logic [63:0] p;
    int          nb, pat;
    c   = 2'($urandom_range(0, 3));
    len = 8'($urandom_range(0, 20));
    nb  = (len == 0) ? 1 : int'(len);
    pat = $urandom_range(0, 2);
    m_start(c);
    for (int i = 0; i < nb; i++) begin
      case (pat)
        0:       p = {$urandom, $urandom};
        1:       p = '1;
        default: p = {32'($urandom_range(0, 7)), 32'($urandom_range(0, 7))};
      endcase
      repeat ($urandom_range(0, 2)) tick();
      // cfg and acc_len on later beats must be ignored
      if (i == 0) send_beat(c, len, p);
      else        send_beat(2'($urandom), 8'($urandom), p);
      m_beat(p);
    end
    expect_result("rnd", m_data(), m_ovfv(), $urandom_range(0, 2));
  endtask

  initial begin
    int hits;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {out_valid, in_ready, ovf, out_data}, '0);
    rst = 1'b1;
    #1;
    chk("rst_rel_ready", in_ready, 1'b0);
    tick();
    chk("first_edge_ready", in_ready, 1'b1);

    // single, 3 beats
    for (int i = 0; i < 3; i++) send_beat(2'b00, 8'd3, 64'hFFFF_0003_0002_0001);
    expect_result("single3", {20'h2FFFD, 20'h00009, 20'h00006, 20'h00003}, 4'b0000, 0);

    // quad, carries cross every slice boundary
    for (int i = 0; i < 2; i++) send_beat(2'b10, 8'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_result("quad2", 80'h1_FFFF_FFFF_FFFF_FFFE, 4'b0000, 0);

    // dual, single beat, result the cycle after acceptance
    send_beat(2'b01, 8'd1, {32'h8000_0000, 32'h0000_0001});
    chk("dual_latency", out_valid, 1'b1);
    expect_result("dual1", {40'h00_8000_0000, 40'h00_0000_0001}, 4'b0000, 0);

    // back-pressure with stalled input beats
    send_beat(2'b00, 8'd0, 64'h0004_0003_0002_0001);
    in_valid = 1'b1;
    prod     = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {out_valid, in_ready, ovf, out_data},
          {1'b1, 1'b0, 4'b0000, 20'h4, 20'h3, 20'h2, 20'h1});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    send_beat(2'b00, 8'd1, 64'h0000_0000_0000_0005);
    expect_result("bp_next", {20'h0, 20'h0, 20'h0, 20'h5}, 4'b0000, 0);

    // lane-0 overflow over 255 beats
    for (int i = 0; i < 255; i++) send_beat(2'b00, 8'd255, 64'h0100_0002_0001_FFFF);
`ifdef MAC_ACC_SATURATE_EN
    expect_result("ovf255", {20'h0FF00, 20'h001FE, 20'h000FF, 20'hFFFFF}, 4'b0001, 1);
`else
    expect_result("ovf255", {20'h0FF00, 20'h001FE, 20'h000FF, 20'hEFF01}, 4'b0001, 1);
`endif

    // reset mid-accumulation discards the partial sum
    for (int i = 0; i < 2; i++) send_beat(2'b00, 8'd4, 64'h0001_0001_0001_0001);
    rst = 1'b0;
    #1;
    chk("midrst_state", {out_valid, in_ready, out_data}, '0);
    repeat (2) tick();
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) hits++;
    end
    chk("midrst_no_result", hits, 0);
    send_beat(2'b00, 8'd1, 64'h0000_0000_0007_0009);
    expect_result("midrst_next", {20'h0, 20'h0, 20'h7, 20'h9}, 4'b0000, 0);

    for (int t = 0; t < 40; t++) rnd_txn();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
